// File: rtl/pipe_bus_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating stall counter for debug.
module pipe_bus_reg #(
  parameter int unsigned BUS_W = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [BUS_W-1:0] up_bus,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [BUS_W-1:0] dn_bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding equals the number of held entries so occupancy is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BUS_W-1:0] main_q, main_d;
  logic [BUS_W-1:0] skid_q, skid_d;
  logic             up_ready_q, up_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic main_vld;
  logic skid_vld;
  logic up_xfer;
  logic dn_xfer;
  logic stall_cyc;

  assign main_vld  = (state_q != StEmpty);
  assign skid_vld  = (state_q == StFull);

  assign up_ready  = up_ready_q;
  assign dn_valid  = main_vld & ~flush;
  assign dn_bus    = main_q;
  assign occupancy = 2'(state_q);
  assign stall_cnt = stall_q;

  assign up_xfer   = up_valid & up_ready_q;
  assign dn_xfer   = dn_valid & dn_ready;
  assign stall_cyc = dn_valid & ~dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Squash: only the valid state clears, data registers keep their contents.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (up_xfer) begin
            state_d = StOne;
            main_d  = up_bus;
          end
        end
        StOne: begin
          if (up_xfer && dn_xfer) begin
            main_d = up_bus;
          end else if (up_xfer) begin
            state_d = StFull;
            skid_d  = up_bus;
          end else if (dn_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (dn_xfer) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    up_ready_d = (state_d != StFull);
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_cyc && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
      stall_q    <= stall_d;
    end
  end

  // A full skid buffer must always be backpressuring upstream.
  full_blocks_up_a: assert property (@(posedge clk) disable iff (!rst_n)
    skid_vld |-> !up_ready_q);

  state_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    state_q != 2'd3);

endmodule

// File: doc/pipe_bus_reg.md
# pipe_bus_reg

Parametrised inter-stage pipeline register for the five-stage RV32 core. It replaces the fixed-width, always-advancing stage buses (IF→ID 64 b, ID→EXE 126 b, EXE→MEM 75 b, MEM→WB 70 b, WB→ID 38 b) with one generic block. The block provides a valid/ready handshake, a two-entry skid buffer, a flush for branch/exception squash, and a saturating stall counter for debug. One instance sits on each stage boundary.

## Interface
Parameters:
- BUS_W, 64, width of the carried stage bus
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous squash of all held entries
- up_valid  in  1  upstream stage presents a bus word
- up_ready  out  1  block can accept a word; registered, with no combinational path from dn_ready
- up_bus  in  BUS_W  upstream bus word
- dn_valid  out  1  block presents a word downstream
- dn_ready  in  1  downstream stage accepts
- dn_bus  out  BUS_W  word presented downstream
- occupancy  out  2  number of held entries (0, 1 or 2)
- stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0; saturates at all-ones

## Operation
- Storage:
  - main register plus valid bit: this is the head, driving dn_bus.
  - skid register plus valid bit.
- Handshakes:
  - up transfer = up_valid & up_ready.
  - dn transfer = dn_valid & dn_ready.
- Output decode:
  - dn_valid = main_valid & ~flush.
  - dn_bus = main register, unmasked. It holds its last value when invalid.
- State machine, encoded by occupancy:
  - EMPTY: up transfer → ONE, main←up_bus.
  - ONE, up only → FULL, skid←up_bus.
  - ONE, dn only → EMPTY.
  - ONE, up and dn together → ONE, main←up_bus.
  - ONE, neither → ONE, hold.
  - FULL: up_ready=0. dn transfer → ONE, main←skid. Otherwise hold.
- up_ready register next value = 1 unless the next state is FULL.
- Flush has priority over everything else:
  - Next state is EMPTY and up_ready←1.
  - An up transfer in the flush cycle is accepted by handshake, then discarded.
  - No dn transfer occurs in the flush cycle because dn_valid is masked.
  - Only the valid bits clear; the data registers keep their contents.
- Stall counter:
  - Increments each cycle dn_valid & ~dn_ready, saturating at 2^CNT_W−1.
  - Not affected by flush; cleared only by reset.
- Ordering: words leave in acceptance order. There is no loss and no duplication except under flush.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - dn_valid=0, up_ready=0, occupancy=0, stall_cnt=0, dn_bus=0.
  - Main and skid valid bits = 0.
- up_ready rises on the first rising clk edge after rst_n deasserts, so nothing is accepted while in reset.
- Reset asserted mid-operation drops all held entries immediately. No transfer completes in that cycle.
- Latency: an up transfer at edge N gives dn_valid=1 with that word after edge N.
- Throughput is one word per cycle while dn_ready is held high. up_ready then stays 1 and occupancy stays ≤1.
- Backpressure:
  - dn_ready low while occupancy=1 and up_valid high: skid fills and up_ready drops after that edge.
  - The skid absorbs exactly the one word that was in flight.
- Release from FULL:
  - The first dn transfer moves skid→main and up_ready returns to 1 after the same edge.
  - No bubble is inserted on dn.
- flush takes effect combinationally on dn_valid in the same cycle. State clears at the following edge.
- stall_cnt changes at the edge ending each qualifying cycle.

## Test plan
- Streaming: BUS_W=64, dn_ready=1, up_valid=1, up_bus=0x1,0x2,…,0x8 on consecutive cycles → dn_bus shows 0x1…0x8 one cycle later, with no gaps. occupancy ≤1, up_ready stays 1, stall_cnt=0.
- Backpressure: send 0xA then 0xB with dn_ready=0 → occupancy=2 and up_ready=0 after the second edge, stall_cnt increments each cycle. Raise dn_ready → dn sees 0xA then 0xB back-to-back, and up_ready returns to 1 after the first transfer.
- Flush with the skid full (0xA, 0xB held), flush=1 together with up_valid=1, up_bus=0xC → dn_valid=0 during the flush cycle, occupancy=0 after it, and none of 0xA/0xB/0xC ever appear. The next word 0xD appears with 1-cycle latency.
- Reset mid-operation: occupancy=2, pull rst_n low between clock edges → dn_valid, up_ready, occupancy and stall_cnt are 0 immediately. After release, up_ready=1 one edge later, and dn_bus=0 until the first accepted word.
- Counter saturation: CNT_W=4, hold dn_valid=1 with dn_ready=0 for 20 cycles → stall_cnt counts to 15 and stays 15. A flush does not clear it.
- Random: random up_valid/dn_ready at 50% each, random flush at 2%, over 10k cycles, checked against a queue model → output order matches and occupancy never exceeds 2.
